axi_lite_periph_slave: RTL and testbench

AXI_LITE_PERIPH_SLAVE -- requirements
Module: axi_lite_periph_slave

---
 rtl/axi_lite_periph_slave_if.sv | 40 ++++
 rtl/axi_lite_periph_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_periph_slave.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_periph_slave_if.sv
// AXI4-Lite bus bundle between the CPU bridge initiator and the peripheral slave.
interface axi_lite_periph_slave_if #(
  parameter int unsigned ADDR_WIDTH = 33
);
  logic [ADDR_WIDTH-1:0] AXI_awaddr;
  logic [2:0]            AXI_awprot;
  logic                  AXI_awvalid;
  logic                  AXI_awready;
  logic [31:0]           AXI_wdata;
  logic [3:0]            AXI_wstrb;
  logic                  AXI_wvalid;
  logic                  AXI_wready;
  logic [1:0]            AXI_bresp;
  logic                  AXI_bvalid;
  logic                  AXI_bready;
  logic [ADDR_WIDTH-1:0] AXI_araddr;
  logic [2:0]            AXI_arprot;
  logic                  AXI_arvalid;
  logic                  AXI_arready;
  logic [31:0]           AXI_rdata;
  logic [1:0]            AXI_rresp;
  logic                  AXI_rvalid;
  logic                  AXI_rready;

  modport master (
    output AXI_awaddr, AXI_awprot, AXI_awvalid, input AXI_awready,
    output AXI_wdata, AXI_wstrb, AXI_wvalid, input AXI_wready,
    input AXI_bresp, AXI_bvalid, output AXI_bready,
    output AXI_araddr, AXI_arprot, AXI_arvalid, input AXI_arready,
    input AXI_rdata, AXI_rresp, AXI_rvalid, output AXI_rready
  );

  modport slave (
    input AXI_awaddr, AXI_awprot, AXI_awvalid, output AXI_awready,
    input AXI_wdata, AXI_wstrb, AXI_wvalid, output AXI_wready,
    output AXI_bresp, AXI_bvalid, input AXI_bready,
    input AXI_araddr, AXI_arprot, AXI_arvalid, output AXI_arready,
    output AXI_rdata, AXI_rresp, AXI_rvalid, input AXI_rready
  );
endinterface

// File: rtl/axi_lite_periph_slave.sv
// AXI4-Lite peripheral: SCRATCH and LED registers, a byte-wide TX FIFO
// drained by the host, and a STATUS register with a sticky overflow flag.
module axi_lite_periph_slave #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    AXI_CLK,
  input  logic                    RESETN,
  axi_lite_periph_slave_if.slave  axi,
  output logic [3:0]              LED,
  output logic [7:0]              fifo_dout,
  output logic                    fifo_valid,
  input  logic                    fifo_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    REG_SCRATCH = 3'd0,
    REG_LED     = 3'd1,
    REG_FIFO    = 3'd2,
    REG_STATUS  = 3'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // write channel latches
  logic        aw_held;
  logic        w_held;
  logic [2:0]  aw_idx;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  resp_e       bresp_q;

  // read channel
  logic        rvalid_q;
  logic [31:0] rdata_q;
  resp_e       rresp_q;
  logic [31:0] rd_data;
  resp_e       rd_resp;

  // registers
  logic [31:0] scratch;
  logic [3:0]  led_q;
  logic        overflow;
  logic [31:0] status;

  // TX FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             ovf_clr;

  logic wr_exec;
  logic aw_fire;
  logic w_fire;
  logic ar_fire;

  // Only addr[4:2] decodes; the rest of the address and the prot fields are don't-care.
  logic unused_inputs;
  assign unused_inputs = ^{axi.AXI_awprot, axi.AXI_arprot,
                           axi.AXI_awaddr[ADDR_WIDTH-1:5], axi.AXI_awaddr[1:0],
                           axi.AXI_araddr[ADDR_WIDTH-1:5], axi.AXI_araddr[1:0]};

  // Readys are gated by RESETN so they read 0 during reset and 1 right after release.
  assign axi.AXI_awready = RESETN && !aw_held && !bvalid_q;
  assign axi.AXI_wready  = RESETN && !w_held && !bvalid_q;
  assign axi.AXI_arready = RESETN && !rvalid_q;
  assign axi.AXI_bvalid  = bvalid_q;
  assign axi.AXI_bresp   = bresp_q;
  assign axi.AXI_rvalid  = rvalid_q;
  assign axi.AXI_rdata   = rdata_q;
  assign axi.AXI_rresp   = rresp_q;

  assign aw_fire = axi.AXI_awvalid && axi.AXI_awready;
  assign w_fire  = axi.AXI_wvalid && axi.AXI_wready;
  assign ar_fire = axi.AXI_arvalid && axi.AXI_arready;
  assign wr_exec = aw_held && w_held && !bvalid_q;

  assign LED        = led_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_valid = !fifo_empty;
  assign fifo_dout  = mem[rd_ptr];

  assign push_req = wr_exec && (aw_idx == REG_FIFO) && wstrb_q[0];
  assign do_push  = push_req && !fifo_full;
  assign do_pop   = fifo_valid && fifo_ready;
  assign ovf_set  = push_req && fifo_full;
  assign ovf_clr  = wr_exec && (aw_idx == REG_STATUS) && wstrb_q[0] && wdata_q[2];

  // STATUS word assembled from live FIFO state
  always_comb begin
    status       = '0;
    status[0]    = fifo_empty;
    status[1]    = fifo_full;
    status[2]    = overflow;
    status[12:8] = 5'(count);
  end

  // read data/response selection for the address currently on AR
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (axi.AXI_araddr[4:2])
      REG_SCRATCH: rd_data = scratch;
      REG_LED:     rd_data[3:0] = led_q;
      REG_FIFO:    rd_data = '0;
      REG_STATUS:  rd_data = status;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // AW/W latching and write response; latches clear on the B handshake
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= axi.AXI_awaddr[4:2];
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= axi.AXI_wdata;
        wstrb_q <= axi.AXI_wstrb;
      end
      if (wr_exec) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_idx[2] ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && axi.AXI_bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  // read response registered on the AR handshake edge, held until rready
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && axi.AXI_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // SCRATCH and LED updates with per-lane strobes
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      scratch <= '0;
      led_q   <= '0;
    end else if (wr_exec) begin
      case (aw_idx)
        REG_SCRATCH: begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb_q[i]) scratch[i*8 +: 8] <= wdata_q[i*8 +: 8];
          end
        end
        REG_LED: begin
          if (wstrb_q[0]) led_q <= wdata_q[3:0];
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO storage, not reset
  always_ff @(posedge AXI_CLK) begin
    if (do_push) mem[wr_ptr] <= wdata_q[7:0];
  end

endmodule

// File: tb/tb_axi_lite_periph_slave.sv
// Self-checking bench for axi_lite_periph_slave with a queue-based reference model.
module tb_axi_lite_periph_slave;

  localparam int AW    = 33;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] led;
  logic [7:0] fifo_dout;
  logic       fifo_valid;
  logic       fifo_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_scratch;
  logic [3:0]  m_led;
  logic        m_ov;
  logic [7:0]  m_q[$];

  axi_lite_periph_slave_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_periph_slave #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .AXI_CLK    (clk),
    .RESETN     (rstn),
    .axi        (bus),
    .LED        (led),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_scratch = '0;
    m_led     = '0;
    m_ov      = 1'b0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    int n;
    n = m_q.size();
    case (idx)
      3'd0:    return m_scratch;
      3'd1:    return {28'b0, m_led};
      3'd3:    return {19'b0, 5'(n), 5'b0, m_ov, n == DEPTH, n == 0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input logic [2:0] idx);
    return (idx >= 3'd4) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    case (idx)
      3'd0: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[b*8 +: 8] = d[b*8 +: 8];
      3'd1: if (s[0]) m_led = d[3:0];
      3'd2: if (s[0]) begin
              if (m_q.size() == DEPTH) m_ov = 1'b1;
              else m_q.push_back(d[7:0]);
            end
      3'd3: if (s[0] && d[2]) m_ov = 1'b0;
      default: ;
    endcase
  endfunction

  // Full write transaction; lat counts edges from last of AW/W accepted to bvalid seen.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit pop,
                          output logic [1:0] resp, output int lat, output bit ok);
    bit aw_done, w_done, aw_f, w_f;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; ok = 0; lat = 0; resp = 2'bxx;
    bus.AXI_bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge clk);
      bus.AXI_awaddr  = addr;
      bus.AXI_awvalid = !aw_done && cyc >= aw_dly;
      bus.AXI_wdata   = data;
      bus.AXI_wstrb   = strb;
      bus.AXI_wvalid  = !w_done && cyc >= w_dly;
      aw_f = bus.AXI_awvalid && bus.AXI_awready;
      w_f  = bus.AXI_wvalid && bus.AXI_wready;
      @(posedge clk);
      if (aw_f) aw_done = 1;
      if (w_f)  w_done = 1;
      cyc++;
    end
    @(negedge clk);
    bus.AXI_awvalid = 1'b0;
    bus.AXI_wvalid  = 1'b0;
    fifo_ready = pop;
    while (!bus.AXI_bvalid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      fifo_ready = 1'b0;
      lat++;
    end
    fifo_ready = 1'b0;
    if (bus.AXI_bvalid && aw_done && w_done) begin
      ok = 1;
      resp = bus.AXI_bresp;
      @(posedge clk);
    end
  endtask

  // Full read transaction; lat counts edges from AR accepted to rvalid seen.
  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output bit ok);
    bit done, f;
    int cyc;
    done = 0; cyc = 0; ok = 0; lat = 0; data = 'x; resp = 2'bxx;
    bus.AXI_rready = 1'b1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      bus.AXI_araddr  = addr;
      bus.AXI_arvalid = 1'b1;
      f = bus.AXI_arready;
      @(posedge clk);
      if (f) done = 1;
      cyc++;
    end
    @(negedge clk);
    bus.AXI_arvalid = 1'b0;
    while (!bus.AXI_rvalid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (bus.AXI_rvalid && done) begin
      ok = 1;
      data = bus.AXI_rdata;
      resp = bus.AXI_rresp;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({bus.AXI_awready, bus.AXI_wready, bus.AXI_arready} !== 3'b000) begin bad++; $display("FAIL rst_readys got=%b exp=000", {bus.AXI_awready, bus.AXI_wready, bus.AXI_arready}); end
    total++; if ({bus.AXI_bvalid, bus.AXI_rvalid, bus.AXI_bresp, bus.AXI_rresp} !== 6'b0) begin bad++; $display("FAIL rst_valid_resp got=%b exp=0", {bus.AXI_bvalid, bus.AXI_rvalid, bus.AXI_bresp, bus.AXI_rresp}); end
    total++; if (bus.AXI_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.AXI_rdata); end
    total++; if ({led, fifo_valid} !== 5'b0) begin bad++; $display("FAIL rst_led_fifo got=%b exp=0", {led, fifo_valid}); end
    rstn = 1'b1;
    #1;
    model_reset();
    total++; if ({bus.AXI_awready, bus.AXI_wready, bus.AXI_arready} !== 3'b111) begin bad++; $display("FAIL post_rst_readys got=%b exp=111", {bus.AXI_awready, bus.AXI_wready, bus.AXI_arready}); end
    do_read(33'h0, d, r, lat, ok);
    total++; if (!ok || d !== 32'h0) begin bad++; $display("FAIL rst_scratch got=%h ok=%0d exp=0", d, ok); end
    do_read(33'hC, d, r, lat, ok);
    total++; if (!ok || d !== 32'h1) begin bad++; $display("FAIL rst_status got=%h ok=%0d exp=1", d, ok); end
  endtask

  task automatic test_led_write();
    logic [1:0] r; int lat; bit ok;
    do_write(33'h4, 32'hA5, 4'h1, 0, 3, 0, r, lat, ok);
    model_write(3'd1, 32'hA5, 4'h1);
    total++; if (!ok || r !== 2'b00) begin bad++; $display("FAIL led_bresp got=%b ok=%0d exp=00", r, ok); end
    total++; if (lat !== 1) begin bad++; $display("FAIL led_b_latency got=%0d exp=1", lat); end
    total++; if (led !== 4'h5) begin bad++; $display("FAIL led_value got=%h exp=5", led); end
  endtask

  task automatic test_scratch_strobe();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    do_write(33'h0, 32'h11223344, 4'hF, 1, 0, 0, r, lat, ok);
    model_write(3'd0, 32'h11223344, 4'hF);
    do_write(33'h0, 32'hFFFFFFFF, 4'h2, 0, 0, 0, r, lat, ok);
    model_write(3'd0, 32'hFFFFFFFF, 4'h2);
    do_read(33'h0, d, r, lat, ok);
    total++; if (!ok || d !== 32'h1122FF44) begin bad++; $display("FAIL scratch_strobe got=%h exp=1122ff44", d); end
    total++; if (lat !== 0 || r !== 2'b00) begin bad++; $display("FAIL scratch_r_timing got_lat=%0d resp=%b exp_lat=0 resp=00", lat, r); end
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    do_read(33'h14, d, r, lat, ok);
    total++; if (!ok || r !== 2'b10 || d !== 32'h0) begin bad++; $display("FAIL slverr_read got=%b/%h exp=10/0", r, d); end
    do_write(33'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, lat, ok);
    total++; if (!ok || r !== 2'b10) begin bad++; $display("FAIL slverr_write got=%b exp=10", r); end
    do_read(33'h0, d, r, lat, ok);
    total++; if (d !== m_scratch) begin bad++; $display("FAIL slverr_scratch got=%h exp=%h", d, m_scratch); end
    total++; if (led !== m_led) begin bad++; $display("FAIL slverr_led got=%h exp=%h", led, m_led); end
  endtask

  task automatic test_drain();
    int guard;
    guard = 0;
    while (m_q.size() > 0 && guard < 2 * DEPTH) begin
      @(negedge clk);
      fifo_ready = 1'b1;
      total++; if (fifo_valid !== 1'b1 || fifo_dout !== m_q[0]) begin bad++; $display("FAIL drain_head got=%b/%h exp=1/%h", fifo_valid, fifo_dout, m_q[0]); end
      @(posedge clk);
      void'(m_q.pop_front());
      guard++;
    end
    @(negedge clk);
    fifo_ready = 1'b0;
    total++; if (fifo_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", fifo_valid); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    for (int i = 0; i <= DEPTH; i++) begin
      do_write(33'h8, 32'(i), 4'h1, 0, 0, 0, r, lat, ok);
      model_write(3'd2, 32'(i), 4'h1);
      total++; if (!ok || r !== 2'b00) begin bad++; $display("FAIL push_bresp i=%0d got=%b exp=00", i, r); end
    end
    do_read(33'hC, d, r, lat, ok);
    total++; if (d !== 32'h00001006) begin bad++; $display("FAIL ovf_status got=%h exp=00001006", d); end
    do_read(33'h8, d, r, lat, ok);
    total++; if (d !== 32'h0 || r !== 2'b00 || m_q.size() != DEPTH) begin bad++; $display("FAIL fifo_data_read got=%h/%b exp=0/00", d, r); end
    test_drain();
    do_write(33'hC, 32'h4, 4'h1, 0, 0, 0, r, lat, ok);
    model_write(3'd3, 32'h4, 4'h1);
    do_read(33'hC, d, r, lat, ok);
    total++; if (d !== 32'h00000001) begin bad++; $display("FAIL w1c_status got=%h exp=00000001", d); end
  endtask

  task automatic test_push_pop_same_edge();
    logic [31:0] d; logic [1:0] r; int lat; bit ok; bit full_before;
    for (int i = 0; i < 3; i++) begin
      do_write(33'h8, 32'hA0 + 32'(i), 4'h1, 0, 0, 0, r, lat, ok);
      model_write(3'd2, 32'hA0 + 32'(i), 4'h1);
    end
    do_write(33'h8, 32'hB0, 4'h1, 0, 0, 1, r, lat, ok);
    void'(m_q.pop_front());
    model_write(3'd2, 32'hB0, 4'h1);
    do_read(33'hC, d, r, lat, ok);
    total++; if (d !== 32'h00000300) begin bad++; $display("FAIL pushpop_count got=%h exp=00000300", d); end
    while (m_q.size() < DEPTH) begin
      do_write(33'h8, 32'hD0 + 32'(m_q.size()), 4'h1, 0, 0, 0, r, lat, ok);
      model_write(3'd2, 32'hD0 + 32'(m_q.size()), 4'h1);
    end
    do_write(33'h8, 32'hCC, 4'h1, 0, 0, 1, r, lat, ok);
    full_before = (m_q.size() == DEPTH);
    void'(m_q.pop_front());
    if (full_before) m_ov = 1'b1; else m_q.push_back(8'hCC);
    do_read(33'hC, d, r, lat, ok);
    total++; if (d !== 32'h00000F04 || d !== model_read(3'd3)) begin bad++; $display("FAIL full_pushpop got=%h exp=00000f04", d); end
    test_drain();
    do_write(33'hC, 32'h4, 4'h1, 0, 0, 0, r, lat, ok);
    model_write(3'd3, 32'h4, 4'h1);
  endtask

  task automatic test_stall();
    logic [31:0] wd, exp_r;
    wd = $urandom;
    exp_r = model_read(3'd1);
    @(negedge clk);
    bus.AXI_bready = 1'b0; bus.AXI_rready = 1'b0;
    bus.AXI_awaddr = 33'h0; bus.AXI_awvalid = 1'b1;
    bus.AXI_wdata = wd; bus.AXI_wstrb = 4'hF; bus.AXI_wvalid = 1'b1;
    bus.AXI_araddr = 33'h4; bus.AXI_arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.AXI_awvalid = 1'b0; bus.AXI_wvalid = 1'b0; bus.AXI_arvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_write(3'd0, wd, 4'hF);
    for (int c = 0; c < 5; c++) begin
      total++; if ({bus.AXI_bvalid, bus.AXI_bresp, bus.AXI_rvalid, bus.AXI_rresp} !== 6'b100100 || bus.AXI_rdata !== exp_r) begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h exp=100100/%h", c, {bus.AXI_bvalid, bus.AXI_bresp, bus.AXI_rvalid, bus.AXI_rresp}, bus.AXI_rdata, exp_r); end
      total++; if ({bus.AXI_awready, bus.AXI_wready, bus.AXI_arready} !== 3'b000) begin bad++; $display("FAIL stall_readys c=%0d got=%b exp=000", c, {bus.AXI_awready, bus.AXI_wready, bus.AXI_arready}); end
      @(posedge clk);
      @(negedge clk);
    end
    bus.AXI_bready = 1'b1; bus.AXI_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({bus.AXI_bvalid, bus.AXI_rvalid, bus.AXI_awready, bus.AXI_wready, bus.AXI_arready} !== 5'b00111) begin bad++; $display("FAIL stall_release got=%b exp=00111", {bus.AXI_bvalid, bus.AXI_rvalid, bus.AXI_awready, bus.AXI_wready, bus.AXI_arready}); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [2:0] idx; logic [31:0] d, wd; logic [3:0] s; logic [1:0] r; int lat; bit ok;
    for (int n = 0; n < 80; n++) begin
      idx = 3'($urandom_range(0, 7));
      a = {1'($urandom), $urandom};
      a[4:2] = idx;
      if ($urandom_range(0, 1) == 0) begin
        wd = $urandom;
        s  = 4'($urandom);
        do_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), 0, r, lat, ok);
        model_write(idx, wd, s);
        total++; if (!ok || r !== model_resp(idx) || lat !== 1) begin bad++; $display("FAIL rnd_write n=%0d idx=%0d got=%b lat=%0d exp=%b lat=1", n, idx, r, lat, model_resp(idx)); end
        total++; if (led !== m_led) begin bad++; $display("FAIL rnd_led n=%0d got=%h exp=%h", n, led, m_led); end
      end else begin
        do_read(a, d, r, lat, ok);
        total++; if (!ok || d !== model_read(idx) || r !== model_resp(idx) || lat !== 0) begin bad++; $display("FAIL rnd_read n=%0d idx=%0d got=%h/%b exp=%h/%b", n, idx, d, r, model_read(idx), model_resp(idx)); end
      end
    end
  endtask

  task automatic test_reset_midtxn();
    logic [1:0] r; int lat; bit ok;
    do_write(33'h4, 32'hF, 4'h1, 0, 0, 0, r, lat, ok);
    model_write(3'd1, 32'hF, 4'h1);
    @(negedge clk);
    bus.AXI_awaddr = 33'h4; bus.AXI_awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.AXI_awvalid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    model_reset();
    total++; if ({bus.AXI_awready, bus.AXI_wready, bus.AXI_arready} !== 3'b111 || led !== 4'h0) begin bad++; $display("FAIL midrst_state got=%b led=%h exp=111 led=0", {bus.AXI_awready, bus.AXI_wready, bus.AXI_arready}, led); end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.AXI_bvalid !== 1'b0) begin bad++; $display("FAIL midrst_no_b got=%b exp=0", bus.AXI_bvalid); end
    end
    do_write(33'h4, 32'h3, 4'h1, 0, 2, 0, r, lat, ok);
    model_write(3'd1, 32'h3, 4'h1);
    total++; if (!ok || led !== 4'h3) begin bad++; $display("FAIL midrst_after got=%h exp=3", led); end
  endtask

  initial begin
    bus.AXI_awaddr = '0; bus.AXI_awprot = '0; bus.AXI_awvalid = 1'b0;
    bus.AXI_wdata = '0; bus.AXI_wstrb = '0; bus.AXI_wvalid = 1'b0;
    bus.AXI_bready = 1'b1;
    bus.AXI_araddr = '0; bus.AXI_arprot = '0; bus.AXI_arvalid = 1'b0;
    bus.AXI_rready = 1'b1;
    model_reset();
    test_reset();
    test_led_write();
    test_scratch_strobe();
    test_slverr();
    test_fifo_overflow();
    test_push_pop_same_edge();
    test_stall();
    test_random();
    test_drain();
    test_reset_midtxn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
